// File: rtl/obi_ram_rr_scheduler.sv
// -----------------------------------------------------------------------------
// obi_ram_rr_scheduler
//
// Purpose:
//   Shares one single-port SRAM port between NUM_REQ OBI requesters. The
//   scheduler issues at most one RAM access per cycle, and accesses are
//   pipelined. Grant and RAM strobe happen in cycle N. The response
//   (rvalid/rdata) returns to the granted requester in cycle N+1. A response
//   is returned for writes as well as reads.
//
// Configuration macro:
//   OBI_ARB_PRIO0_EN - When defined, requester 0 has strict priority. Ports
//                      1..NUM_REQ-1 round-robin among themselves, and the
//                      pointer only advances on their grants. When undefined,
//                      all ports take part in pure round-robin.
//
// Ports:
//   clk_i        - Clock. All logic runs on the rising edge.
//   rst_i        - Synchronous, active-high reset. Also blocks grants
//                  combinationally.
//   stall_i      - RAM port unavailable this cycle. No grant is issued.
//   req_i        - OBI request, one bit per requester.
//   addr_i       - Packed byte addresses. Requester k is at [k*AW +: AW].
//   we_i         - Packed write enables.
//   be_i         - Packed byte enables.
//   wdata_i      - Packed write data.
//   gnt_o        - One-hot (or zero) grant. Combinational.
//   rvalid_o     - One-hot (or zero) response valid. Registered.
//   rdata_o      - Shared read data. Passed straight through from the RAM.
//   ram_en_o     - RAM access strobe.
//   ram_we_o     - RAM write enable. Only meaningful with ram_en_o.
//   ram_be_o     - RAM byte enables.
//   ram_addr_o   - RAM word address.
//   ram_wdata_o  - RAM write data.
//   ram_rdata_i  - RAM read data. Valid one cycle after ram_en_o.
// -----------------------------------------------------------------------------
module obi_ram_rr_scheduler #(
  parameter int NUM_REQ        = 3,
  parameter int SOC_ADDR_WIDTH = 32,
  parameter int RAM_ADDR_WIDTH = 12,
  parameter int RAM_DATA_WIDTH = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          stall_i,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*SOC_ADDR_WIDTH-1:0] addr_i,
  input  logic [NUM_REQ-1:0]            we_i,
  input  logic [NUM_REQ*RAM_DATA_WIDTH/8-1:0] be_i,
  input  logic [NUM_REQ*RAM_DATA_WIDTH-1:0]   wdata_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic [NUM_REQ-1:0]            rvalid_o,
  output logic [RAM_DATA_WIDTH-1:0]     rdata_o,
  output logic                          ram_en_o,
  output logic                          ram_we_o,
  output logic [RAM_DATA_WIDTH/8-1:0]   ram_be_o,
  output logic [RAM_ADDR_WIDTH-1:0]     ram_addr_o,
  output logic [RAM_DATA_WIDTH-1:0]     ram_wdata_o,
  input  logic [RAM_DATA_WIDTH-1:0]     ram_rdata_i
);

  localparam int BE_W  = RAM_DATA_WIDTH / 8;
  localparam int ALIGN = $clog2(BE_W);
  localparam int PW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
  logic [PW-1:0]      win_idx_s;
  logic               win_vld_s;
  logic               grant_s;
  logic [NUM_REQ-1:0] gnt_s;

  // Only the word-address bits of each byte address reach the RAM.
  logic unused_addr_bits_s;
  assign unused_addr_bits_s = ^addr_i;

  // Find the first requesting port, searching upward from rr_ptr with wrap.
  always_comb begin
    logic [PW:0] cand;
    cand      = '0;
    win_idx_s = '0;
    win_vld_s = 1'b0;
`ifdef OBI_ARB_PRIO0_EN
    if (req_i[0]) begin
      // Port 0 preempts the rotation entirely.
      win_idx_s = '0;
      win_vld_s = 1'b1;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cand = {1'b0, rr_ptr_q} + (PW+1)'(i);
        if (cand >= (PW+1)'(NUM_REQ)) begin
          cand = cand - (PW+1)'(NUM_REQ);
        end else begin
          cand = cand;
        end
        if (!win_vld_s && (cand != '0) && req_i[cand[PW-1:0]]) begin
          win_idx_s = cand[PW-1:0];
          win_vld_s = 1'b1;
        end else begin
          win_vld_s = win_vld_s;
        end
      end
    end
`else
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr_q} + (PW+1)'(i);
      if (cand >= (PW+1)'(NUM_REQ)) begin
        cand = cand - (PW+1)'(NUM_REQ);
      end else begin
        cand = cand;
      end
      if (!win_vld_s && req_i[cand[PW-1:0]]) begin
        win_idx_s = cand[PW-1:0];
        win_vld_s = 1'b1;
      end else begin
        win_vld_s = win_vld_s;
      end
    end
`endif
  end

  // A grant needs a winner, a free RAM port and no reset in progress.
  assign grant_s = win_vld_s & ~stall_i & ~rst_i;
  assign gnt_o   = gnt_s;

  // Grant vector and RAM request mux from the winning port.
  always_comb begin
    if (grant_s) begin
      gnt_s = ONE_HOT0 << win_idx_s;
    end else begin
      gnt_s = '0;
    end
    ram_en_o    = grant_s;
    ram_we_o    = grant_s & we_i[win_idx_s];
    ram_be_o    = be_i[int'(win_idx_s)*BE_W +: BE_W];
    ram_addr_o  = addr_i[int'(win_idx_s)*SOC_ADDR_WIDTH + ALIGN +: RAM_ADDR_WIDTH];
    ram_wdata_o = wdata_i[int'(win_idx_s)*RAM_DATA_WIDTH +: RAM_DATA_WIDTH];
  end

  // Next-state logic: the pointer moves past the winner, and rvalid tracks the grant.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    rvalid_d = '0;
    if (grant_s) begin
      rvalid_d = gnt_s;
`ifdef OBI_ARB_PRIO0_EN
      // Priority grants to port 0 leave the rotation of 1..N-1 untouched.
      if (win_idx_s == '0) begin
        rr_ptr_d = rr_ptr_q;
      end else if (win_idx_s == PW'(NUM_REQ-1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = win_idx_s + PW'(1);
      end
`else
      if (win_idx_s == PW'(NUM_REQ-1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = win_idx_s + PW'(1);
      end
`endif
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q <= '0;
      rvalid_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = ram_rdata_i;

endmodule
